// File: rtl/usb_sie_phase_sequencer_if.sv
// usb_sie_phase_sequencer_if
//   Groups the handshake signals between the SIE phase sequencer, the SIE and
//   the protocol layer. Signal names keep the sequencer's point of view:
//   *_i are driven towards the sequencer, *_o are driven by it.
//
//   master : the sequencer itself (drives isSendingPhase, grant, pulses)
//   slave  : the SIE / protocol-layer side (drives the status inputs)
//
//   usbResetDetected_i   level from SIE: bus reset condition present
//   ackUsbResetDetect_o  one-cycle ack back to the SIE
//   rxDPPLGotSignal_i    DPPL locked on an incoming packet
//   rxPacketDone_i       pulse: last rx byte consumed
//   txReq_i              level: protocol layer has a response
//   expectResp_i         qualifies txDoneSending_i: host handshake expected
//   txDoneSending_i      pulse from SIE: transmission finished
//   isSendingPhase_o     datapath direction to SIE
//   txGrant_o            protocol layer may drive the SIE tx interface
//   respTimeout_o        one-cycle pulse: host handshake never arrived
//   busReset_o           one-cycle pulse: bus reset entered
interface usb_sie_phase_sequencer_if;
  logic usbResetDetected_i;
  logic ackUsbResetDetect_o;
  logic rxDPPLGotSignal_i;
  logic rxPacketDone_i;
  logic txReq_i;
  logic expectResp_i;
  logic txDoneSending_i;
  logic isSendingPhase_o;
  logic txGrant_o;
  logic respTimeout_o;
  logic busReset_o;

  modport master (
    input  usbResetDetected_i, rxDPPLGotSignal_i, rxPacketDone_i, txReq_i,
           expectResp_i, txDoneSending_i,
    output ackUsbResetDetect_o, isSendingPhase_o, txGrant_o, respTimeout_o,
           busReset_o
  );

  modport slave (
    output usbResetDetected_i, rxDPPLGotSignal_i, rxPacketDone_i, txReq_i,
           expectResp_i, txDoneSending_i,
    input  ackUsbResetDetect_o, isSendingPhase_o, txGrant_o, respTimeout_o,
           busReset_o
  );
endinterface

// File: rtl/usb_sie_phase_sequencer.sv
// usb_sie_phase_sequencer
//   Sequences the shared SIE datapath between receive and transmit: waits for
//   a response decision after a received packet, inserts bus turnaround,
//   grants transmit, then optionally waits for the host handshake. A bus
//   reset from the SIE overrides everything.
//
//   Ports:
//     clk48_i  48 MHz clock
//     rstn_i   asynchronous active-low reset
//     bus      usb_sie_phase_sequencer_if.master (see interface header)
//
//   Parameters:
//     TURNAROUND_CYCLES   turnaround length before the phase switches to tx
//     RESP_WINDOW_CYCLES  cycles after rxPacketDone_i in which txReq_i counts
//     TIMEOUT_CYCLES      host handshake wait after own transmission
//
//   Build option: define USB_SIE_SEQ_RESP_TIMEOUT_EN to enable the handshake
//   timeout; without it WAIT_RESP waits for the DPPL or a bus reset and
//   respTimeout_o is tied low.
//
//   Outputs are registered from the state register, so they follow a state
//   change by one edge (e.g. txReq_i sampled at edge M raises isSendingPhase_o
//   at edge M+1+TURNAROUND_CYCLES).
module usb_sie_phase_sequencer #(
  parameter int TURNAROUND_CYCLES  = 8,
  parameter int RESP_WINDOW_CYCLES = 20,
  parameter int TIMEOUT_CYCLES     = 72
) (
  input logic                        clk48_i,
  input logic                        rstn_i,
  usb_sie_phase_sequencer_if.master  bus
);

  localparam int MAX_TA = (TURNAROUND_CYCLES > RESP_WINDOW_CYCLES) ?
                          TURNAROUND_CYCLES : RESP_WINDOW_CYCLES;
  localparam int MAX_P  = (MAX_TA > TIMEOUT_CYCLES) ? MAX_TA : TIMEOUT_CYCLES;
  localparam int CNT_W  = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    S_RX, S_DECIDE, S_TURNAROUND, S_TX, S_WAIT_RESP, S_BUS_RESET
  } state_t;

  // Saturating decrement of the shared phase counter.
  function automatic cnt_t satDec(input cnt_t c);
    return (c == '0) ? '0 : c - cnt_t'(1);
  endfunction

  // The counter "reaches 0" on the edge where it steps from 1 to 0; a load
  // of 0 expires on the first edge, giving a single-cycle pass.
  function automatic logic cntExpiring(input cnt_t c);
    return (c <= cnt_t'(1));
  endfunction

  state_t state_p0, stateNext;
  cnt_t   cnt_p0, cntNext;
  logic   firstInState_p0;
  logic   dpplPrev_p0;
  logic   dpplRise;

  logic   isSendingPhase_p1, txGrant_p1, ackUsbResetDetect_p1, busReset_p1;
  logic   isSendingPhaseNext, txGrantNext, ackNext, busResetNext;
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
  logic   timeoutHit_p0, timeoutHitNext;
  logic   respTimeout_p1, respTimeoutNext;
`endif

  assign dpplRise = bus.rxDPPLGotSignal_i & ~dpplPrev_p0;

  // ---- stage p0: state, counter and entry flag; stage p1: output registers
  always_ff @(posedge clk48_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_p0             <= S_RX;
      cnt_p0               <= '0;
      firstInState_p0      <= 1'b0;
      dpplPrev_p0          <= 1'b0;
      isSendingPhase_p1    <= 1'b0;
      txGrant_p1           <= 1'b0;
      ackUsbResetDetect_p1 <= 1'b0;
      busReset_p1          <= 1'b0;
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
      timeoutHit_p0        <= 1'b0;
      respTimeout_p1       <= 1'b0;
`endif
    end else begin
      state_p0             <= stateNext;
      cnt_p0               <= cntNext;
      firstInState_p0      <= (stateNext != state_p0);
      dpplPrev_p0          <= bus.rxDPPLGotSignal_i;
      isSendingPhase_p1    <= isSendingPhaseNext;
      txGrant_p1           <= txGrantNext;
      ackUsbResetDetect_p1 <= ackNext;
      busReset_p1          <= busResetNext;
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
      timeoutHit_p0        <= timeoutHitNext;
      respTimeout_p1       <= respTimeoutNext;
`endif
    end
  end

  always_comb begin
    stateNext = state_p0;
    cntNext   = satDec(cnt_p0);
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
    timeoutHitNext = 1'b0;
`endif
    if (bus.usbResetDetected_i) begin
      stateNext = S_BUS_RESET;
    end else begin
      unique case (state_p0)
        S_RX: begin
          if (bus.rxPacketDone_i) begin
            stateNext = S_DECIDE;
            cntNext   = cnt_t'(RESP_WINDOW_CYCLES);
          end
        end
        S_DECIDE: begin
          // A new incoming packet cancels the pending response decision.
          if (dpplRise) begin
            stateNext = S_RX;
          end else if (bus.txReq_i) begin
            stateNext = S_TURNAROUND;
            cntNext   = cnt_t'(TURNAROUND_CYCLES);
          end else if (cntExpiring(cnt_p0)) begin
            stateNext = S_RX;
          end
        end
        S_TURNAROUND: begin
          if (cntExpiring(cnt_p0)) stateNext = S_TX;
        end
        S_TX: begin
          if (bus.txDoneSending_i) begin
            if (bus.expectResp_i) begin
              stateNext = S_WAIT_RESP;
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
              cntNext   = cnt_t'(TIMEOUT_CYCLES);
`endif
            end else begin
              stateNext = S_RX;
            end
          end
        end
        S_WAIT_RESP: begin
          // The DPPL is reset by the phase fall, so its lock indication in the
          // first cycle here is stale and must not count as the handshake.
          if (!firstInState_p0 && bus.rxDPPLGotSignal_i) begin
            stateNext = S_RX;
          end
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
          else if (cntExpiring(cnt_p0)) begin
            stateNext      = S_RX;
            timeoutHitNext = 1'b1;
          end
`endif
        end
        S_BUS_RESET: stateNext = S_RX;
        default:     stateNext = S_RX;
      endcase
    end
  end

  always_comb begin
    isSendingPhaseNext = (state_p0 == S_TX);
    txGrantNext        = (state_p0 == S_TX);
    ackNext            = (state_p0 == S_BUS_RESET) && firstInState_p0;
    busResetNext       = (state_p0 == S_BUS_RESET) && firstInState_p0;
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
    respTimeoutNext    = timeoutHit_p0;
`endif
  end

  assign bus.isSendingPhase_o    = isSendingPhase_p1;
  assign bus.txGrant_o           = txGrant_p1;
  assign bus.ackUsbResetDetect_o = ackUsbResetDetect_p1;
  assign bus.busReset_o          = busReset_p1;
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
  assign bus.respTimeout_o       = respTimeout_p1;
`else
  assign bus.respTimeout_o       = 1'b0;
`endif

endmodule

// File: tb/tb_usb_sie_phase_sequencer.sv
// tb_usb_sie_phase_sequencer
//   Directed vector table, hand-written corner sequences and a randomized run
//   against a timestamp-based reference model of the sequencer.
//   Output vector order: {isSendingPhase, txGrant, ack, busReset, respTimeout}
//   Stimulus order:      {rxPacketDone, txReq, txDone, expectResp, dppl, usbReset}
module tb_usb_sie_phase_sequencer;

  localparam int TURN = 8;
  localparam int RESP = 20;
  localparam int TO   = 72;
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk48 = 1'b0;
  logic rstn  = 1'b0;
  always #5 clk48 = ~clk48;

  usb_sie_phase_sequencer_if bus();

  usb_sie_phase_sequencer #(
    .TURNAROUND_CYCLES (TURN),
    .RESP_WINDOW_CYCLES(RESP),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clk48_i(clk48),
    .rstn_i (rstn),
    .bus    (bus)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int         n;
    logic [5:0] stim;
    logic [4:0] exp;
    string      nm;
  } vec_t;
  vec_t tbl[$];

  // ---------------- reference model (phases with absolute deadlines)
  localparam int PH_IDLE = 0, PH_WINDOW = 1, PH_TURN = 2, PH_SEND = 3,
                 PH_AWAIT = 4, PH_RESET = 5;
  int mPhase, mEntered, mDeadline, edgeNo;
  bit mTimedOut, mPrevDppl;

  function automatic int atLeast1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  task automatic modelReset();
    mPhase = PH_IDLE; mEntered = -10; mDeadline = 0; edgeNo = 0;
    mTimedOut = 1'b0; mPrevDppl = 1'b0;
  endtask

  // Called at each rising edge: returns outputs expected after this edge
  // (they reflect the phase held before it), then advances the model.
  task automatic modelStep(output logic [4:0] exp);
    int e; int nxt; bit to; bit rise; bit firstRst;
    edgeNo++;
    e = edgeNo;
    firstRst = (mPhase == PH_RESET) && (mEntered == e - 1);
    exp = {mPhase == PH_SEND, mPhase == PH_SEND, firstRst, firstRst, mTimedOut};
    rise = bus.rxDPPLGotSignal_i && !mPrevDppl;
    mPrevDppl = bus.rxDPPLGotSignal_i;
    nxt = mPhase; to = 1'b0;
    if (bus.usbResetDetected_i) nxt = PH_RESET;
    else begin
      case (mPhase)
        PH_IDLE:   if (bus.rxPacketDone_i) begin nxt = PH_WINDOW; mDeadline = e + atLeast1(RESP); end
        PH_WINDOW: begin
          if (rise) nxt = PH_IDLE;
          else if (bus.txReq_i) begin nxt = PH_TURN; mDeadline = e + atLeast1(TURN); end
          else if (e >= mDeadline) nxt = PH_IDLE;
        end
        PH_TURN:   if (e >= mDeadline) nxt = PH_SEND;
        PH_SEND:   if (bus.txDoneSending_i) begin
                     if (bus.expectResp_i) begin nxt = PH_AWAIT; mDeadline = e + atLeast1(TO); end
                     else nxt = PH_IDLE;
                   end
        PH_AWAIT: begin
          if (bus.rxDPPLGotSignal_i && e >= mEntered + 2) nxt = PH_IDLE;
          else if (TO_EN && e >= mDeadline) begin nxt = PH_IDLE; to = 1'b1; end
        end
        default:   nxt = PH_IDLE;
      endcase
    end
    if (nxt != mPhase) mEntered = e;
    mPhase = nxt;
    mTimedOut = to;
  endtask

  // ---------------- helpers
  function automatic logic [4:0] outVec();
    return {bus.isSendingPhase_o, bus.txGrant_o, bus.ackUsbResetDetect_o,
            bus.busReset_o, bus.respTimeout_o};
  endfunction

  task automatic check(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic checkInt(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic applyStim(input logic [5:0] s);
    bus.rxPacketDone_i     = s[5];
    bus.txReq_i            = s[4];
    bus.txDoneSending_i    = s[3];
    bus.expectResp_i       = s[2];
    bus.rxDPPLGotSignal_i  = s[1];
    bus.usbResetDetected_i = s[0];
  endtask

  task automatic step();
    @(posedge clk48);
    @(negedge clk48);
  endtask

  task automatic addVec(input int n, input logic [5:0] s, input logic [4:0] e, input string nm);
    vec_t v;
    v.n = n; v.stim = s; v.exp = e; v.nm = nm;
    tbl.push_back(v);
  endtask

  task automatic doReset();
    applyStim(6'b0);
    rstn = 1'b0;
    repeat (2) @(negedge clk48);
    check("reset_state", outVec(), 5'b00000);
    rstn = 1'b1;
    modelReset();
  endtask

  // rxPacketDone, txReq next cycle, then wait out the turnaround.
  task automatic runToTx();
    applyStim(6'b100000); step();
    applyStim(6'b010000); step();
    applyStim(6'b000000);
    repeat (TURN + 1) step();
    check("enter_tx", outVec(), 5'b11000);
  endtask

  task automatic exitViaBusReset();
    applyStim(6'b000001); step(); step();
    applyStim(6'b000000); step(); step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] expv;
    int pulses, first, anySend;
    bit ures;

    addVec(1,  6'b100000, 5'b00000, "pktdone");
    addVec(1,  6'b000000, 5'b00000, "decide");
    addVec(1,  6'b010000, 5'b00000, "txreq");
    addVec(8,  6'b000000, 5'b00000, "turnaround");
    addVec(3,  6'b000000, 5'b11000, "tx");
    addVec(1,  6'b001110, 5'b11000, "txdone_exp");
    addVec(1,  6'b000010, 5'b00000, "wait_first");
    addVec(1,  6'b000010, 5'b00000, "wait_second");
    addVec(1,  6'b000000, 5'b00000, "rx_back");
    addVec(1,  6'b100000, 5'b00000, "pktdone2");
    addVec(1,  6'b010000, 5'b00000, "txreq2");
    addVec(8,  6'b000000, 5'b00000, "turn2");
    addVec(1,  6'b000000, 5'b11000, "tx2");
    addVec(1,  6'b001000, 5'b11000, "txdone_noexp");
    addVec(1,  6'b000000, 5'b00000, "rx3");
    addVec(1,  6'b100000, 5'b00000, "pktdone3");
    addVec(20, 6'b000000, 5'b00000, "window");
    addVec(1,  6'b010000, 5'b00000, "late_req");
    addVec(12, 6'b000000, 5'b00000, "late_ignored");
    addVec(1,  6'b100000, 5'b00000, "pktdone4");
    addVec(19, 6'b000000, 5'b00000, "window4");
    addVec(1,  6'b010000, 5'b00000, "last_req");
    addVec(8,  6'b000000, 5'b00000, "turn4");
    addVec(1,  6'b000000, 5'b11000, "tx4");
    addVec(1,  6'b000001, 5'b11000, "busrst_in");
    addVec(1,  6'b000001, 5'b00110, "busrst_ack");
    addVec(3,  6'b000001, 5'b00000, "busrst_hold");
    addVec(1,  6'b000000, 5'b00000, "busrst_rel");
    addVec(1,  6'b000000, 5'b00000, "rx5");
    addVec(1,  6'b100000, 5'b00000, "pktdone5");
    addVec(1,  6'b010010, 5'b00000, "dppl_vs_req");
    addVec(10, 6'b000000, 5'b00000, "dppl_wins");

    applyStim(6'b0);
    doReset();
    for (int i = 0; i < tbl.size(); i++) begin
      applyStim(tbl[i].stim);
      for (int k = 0; k < tbl[i].n; k++) begin
        step();
        check(tbl[i].nm, outVec(), tbl[i].exp);
      end
    end

    // Handshake timeout: pulse 73 cycles after txDoneSending, once.
    doReset();
    runToTx();
    applyStim(6'b001100); step();
    applyStim(6'b000000);
    pulses = 0; first = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.respTimeout_o === 1'b1) begin
        pulses++;
        if (first == 0) first = i;
      end
    end
`ifdef USB_SIE_SEQ_RESP_TIMEOUT_EN
    checkInt("timeout_pulses", pulses, 1);
    checkInt("timeout_delay", first, TO + 1);
`else
    checkInt("timeout_pulses", pulses, 0);
`endif
    exitViaBusReset();

    // DPPL only in the first WAIT_RESP cycle must not end the wait.
    doReset();
    runToTx();
    applyStim(6'b001100); step();
    applyStim(6'b000010); step();
    applyStim(6'b000000); step();
    applyStim(6'b100000); step();
    applyStim(6'b010000); step();
    applyStim(6'b000000);
    anySend = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.isSendingPhase_o === 1'b1) anySend++;
    end
    checkInt("dppl_first_ignored", anySend, 0);
    exitViaBusReset();

    // Async reset mid-TX drops outputs without a clock edge.
    doReset();
    runToTx();
    #2 rstn = 1'b0;
    #1 check("async_rst_tx", outVec(), 5'b00000);
    @(negedge clk48);
    rstn = 1'b1;
    applyStim(6'b010000);
    repeat (3) step();
    check("rx_after_rst", outVec(), 5'b00000);
    applyStim(6'b000000);
    runToTx();

    // Async reset during turnaround: no transmit after release.
    doReset();
    applyStim(6'b100000); step();
    applyStim(6'b010000); step();
    applyStim(6'b000000);
    repeat (3) step();
    #2 rstn = 1'b0;
    #1 check("async_rst_turn", outVec(), 5'b00000);
    @(negedge clk48);
    rstn = 1'b1;
    anySend = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.isSendingPhase_o === 1'b1) anySend++;
    end
    checkInt("no_tx_after_rst", anySend, 0);
    runToTx();

    // Randomized run against the reference model.
    doReset();
    ures = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if (ures) ures = ($urandom_range(0, 3) != 0);
      else      ures = ($urandom_range(0, 299) == 0);
      bus.usbResetDetected_i = ures;
      bus.rxPacketDone_i     = ($urandom_range(0, 5) == 0);
      bus.txReq_i            = ($urandom_range(0, 2) == 0);
      bus.txDoneSending_i    = ($urandom_range(0, 9) == 0);
      bus.expectResp_i       = ($urandom_range(0, 1) == 0);
      if ($urandom_range(0, 9) == 0) bus.rxDPPLGotSignal_i = ~bus.rxDPPLGotSignal_i;
      @(posedge clk48);
      modelStep(expv);
      @(negedge clk48);
      check("random", outVec(), expv);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
